mul_share_ctrl: RTL and testbench

Arbitration and sequencing controller that shares one 8-bit Booth radix-2 multiplier datapath among NUM_REQ requesters. It picks requests round-robin and drives the multiplier's start/operand interface. It holds operands stable for the whole computation, detects completion and returns the signed 16-bit product with the requester's tag on one response channel with valid/ready backpressure. It sits between the ALU front-end requesters and the multiplier instance.

---
 rtl/mul_share_ctrl_if.sv | 33 +++
 rtl/mul_share_ctrl.sv | 141 ++++++++++++++
 tb/tb_mul_share_ctrl.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_share_ctrl_if.sv
// Request, response and multiplier-side signals shared between the controller
// and its environment.
interface mul_share_ctrl_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TAG_W   = 2
) ();
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [8*NUM_REQ-1:0] req_a;
  logic [8*NUM_REQ-1:0] req_b;
  logic                 res_valid;
  logic                 res_ready;
  logic [TAG_W-1:0]     res_tag;
  logic [15:0]          res_product;
  logic                 mul_start;
  logic [7:0]           mul_multiplicand;
  logic [7:0]           mul_multiplier;
  logic [15:0]          mul_product;
  logic                 mul_done;
  logic                 busy;

  modport slave (
    input  req_valid, req_a, req_b, res_ready, mul_product, mul_done,
    output req_ready, res_valid, res_tag, res_product, mul_start,
           mul_multiplicand, mul_multiplier, busy
  );

  modport master (
    output req_valid, req_a, req_b, res_ready, mul_product, mul_done,
    input  req_ready, res_valid, res_tag, res_product, mul_start,
           mul_multiplicand, mul_multiplier, busy
  );
endinterface

// File: rtl/mul_share_ctrl.sv
// Round-robin arbiter and sequencer sharing one 8x8 signed multiplier among
// NUM_REQ requesters, returning tagged products over a valid/ready channel.
module mul_share_ctrl #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TAG_W   = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  mul_share_ctrl_if.slave bus
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [TAG_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [7:0]         opa_q, opa_d;
  logic [7:0]         opb_q, opb_d;
  logic               blank_q, blank_d;
  logic               mul_start_q, mul_start_d;
  logic               res_valid_q, res_valid_d;
  logic               busy_q, busy_d;
  logic [15:0]        res_product_q, res_product_d;
  logic [NUM_REQ-1:0] req_ready_c;

  logic [7:0]         a_arr [NUM_REQ];
  logic [7:0]         b_arr [NUM_REQ];
  logic               grant_found_c;
  logic [IDX_W-1:0]   grant_idx_c;

  // Round-robin search: the lowest offset from rr_ptr_q with a valid request wins.
  always_comb begin
    int unsigned cand;
    cand          = '0;
    grant_found_c = 1'b0;
    grant_idx_c   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      a_arr[i] = bus.req_a[8*i +: 8];
      b_arr[i] = bus.req_b[8*i +: 8];
    end
    for (int unsigned k = NUM_REQ; k > 0; k--) begin
      cand = (32'(rr_ptr_q) + k - 32'd1) % NUM_REQ;
      if (bus.req_valid[IDX_W'(cand)]) begin
        grant_found_c = 1'b1;
        grant_idx_c   = IDX_W'(cand);
      end
    end
  end

  // Next-state and register-input logic.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    tag_d         = tag_q;
    opa_d         = opa_q;
    opb_d         = opb_q;
    blank_d       = 1'b0;
    mul_start_d   = 1'b0;
    res_valid_d   = res_valid_q;
    res_product_d = res_product_q;
    req_ready_c   = '0;

    case (state_q)
      S_IDLE: begin
        if (grant_found_c) begin
          req_ready_c[grant_idx_c] = 1'b1;
          opa_d       = a_arr[grant_idx_c];
          opb_d       = b_arr[grant_idx_c];
          tag_d       = TAG_W'(grant_idx_c);
          rr_ptr_d    = TAG_W'((32'(grant_idx_c) + 32'd1) % NUM_REQ);
          mul_start_d = 1'b1;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        blank_d = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // blank_q masks a stale done left over from the previous operation
        if (!blank_q && bus.mul_done) begin
          res_product_d = bus.mul_product;
          res_valid_d   = 1'b1;
          state_d       = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      rr_ptr_q      <= '0;
      tag_q         <= '0;
      opa_q         <= '0;
      opb_q         <= '0;
      blank_q       <= 1'b0;
      mul_start_q   <= 1'b0;
      res_valid_q   <= 1'b0;
      res_product_q <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      tag_q         <= tag_d;
      opa_q         <= opa_d;
      opb_q         <= opb_d;
      blank_q       <= blank_d;
      mul_start_q   <= mul_start_d;
      res_valid_q   <= res_valid_d;
      res_product_q <= res_product_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.req_ready        = req_ready_c;
  assign bus.mul_start        = mul_start_q;
  assign bus.mul_multiplicand = opa_q;
  assign bus.mul_multiplier   = opb_q;
  assign bus.res_valid        = res_valid_q;
  assign bus.res_tag          = tag_q;
  assign bus.res_product      = res_product_q;
  assign bus.busy             = busy_q;

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Scoreboard bench for mul_share_ctrl with a behavioural 9-cycle multiplier.
module tb_mul_share_ctrl;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned TAG_W   = 2;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [15:0]      prod;
    int               acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic inj_done = 1'b0;
  always #5 clk = ~clk;

  mul_share_ctrl_if #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) bus ();

  mul_share_ctrl #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   last_rsp_cyc = 0;
  int   n_rsp = 0;
  exp_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier model: done when count reaches 0; product is garbage while busy.
  int unsigned mcount = 0;
  logic [7:0]  lat_a = 8'h00;
  logic [7:0]  lat_b = 8'h00;
  logic [15:0] mprod = 16'h0000;
  logic        op_bad = 1'b0;

  always @(posedge clk) begin
    if (bus.mul_start) begin
      mcount <= 8;
      lat_a  <= bus.mul_multiplicand;
      lat_b  <= bus.mul_multiplier;
      mprod  <= 16'(int'($signed(bus.mul_multiplicand)) * int'($signed(bus.mul_multiplier)));
      op_bad <= 1'b0;
    end else if (mcount != 0) begin
      mcount <= mcount - 1;
      if (bus.mul_multiplicand != lat_a || bus.mul_multiplier != lat_b) op_bad <= 1'b1;
    end
  end

  assign bus.mul_done    = (mcount == 0) || inj_done;
  assign bus.mul_product = (mcount == 0) ? mprod : 16'hDEAD;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor: pops the scoreboard on every response handshake.
  initial begin : mon
    logic prev_v;
    int   rise;
    exp_t e;
    prev_v = 1'b0;
    rise   = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_v = 1'b0;
      end else begin
        if (bus.res_valid && !prev_v) rise = cyc;
        prev_v = bus.res_valid;
        if (bus.res_valid && bus.res_ready) begin
          last_rsp_cyc = cyc;
          n_rsp++;
          chk("rsp_expected", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("rsp_tag", 32'(bus.res_tag), 32'(e.tag));
            chk("rsp_product", 32'(bus.res_product), 32'(e.prod));
            chk("rsp_latency", 32'(rise - e.acc), 32'd11);
            chk("operand_stable", 32'(op_bad), 32'd0);
          end
        end
      end
    end
  end

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b);
    bus.req_a[8*i +: 8] = a;
    bus.req_b[8*i +: 8] = b;
  endtask

  // Single request: returns at the ISSUE cycle (+1ns) with the accept cycle.
  task automatic issue_one(input int i, input logic [7:0] a, input logic [7:0] b,
                           input logic [15:0] p, output int acc);
    exp_t e;
    acc = -1;
    set_req(i, a, b);
    bus.req_valid[i] = 1'b1;
    for (int n = 0; n < 100; n++) begin
      #1;
      if (bus.req_ready[i]) begin
        acc   = cyc;
        e.tag = TAG_W'(i);
        e.prod = p;
        e.acc = cyc;
        sb.push_back(e);
        chk("ready_onehot", 32'($countones(bus.req_ready)), 32'd1);
      end
      @(posedge clk); #1;
      if (acc >= 0) break;
    end
    bus.req_valid[i] = 1'b0;
    chk("accept_seen", 32'(acc >= 0), 32'd1);
  endtask

  int          pend_init [NUM_REQ];
  logic [15:0] eprod [NUM_REQ];
  int          ord[$];

  // Several concurrent requesters; grants must follow ord.
  task automatic serve();
    int   pend [NUM_REQ];
    int   k;
    int   idx;
    exp_t e;
    k = 0;
    for (int i = 0; i < NUM_REQ; i++) pend[i] = pend_init[i];
    for (int n = 0; n < 400 && k < ord.size(); n++) begin
      for (int i = 0; i < NUM_REQ; i++) bus.req_valid[i] = (pend[i] > 0);
      #1;
      if (bus.req_ready != '0) begin
        idx = 0;
        for (int i = 0; i < NUM_REQ; i++) if (bus.req_ready[i]) idx = i;
        chk("ready_onehot", 32'($countones(bus.req_ready)), 32'd1);
        chk("grant_order", 32'(idx), 32'(ord[k]));
        e.tag  = TAG_W'(ord[k]);
        e.prod = eprod[ord[k]];
        e.acc  = cyc;
        sb.push_back(e);
        if (pend[idx] > 0) pend[idx]--;
        k++;
      end
      @(posedge clk); #1;
    end
    bus.req_valid = '0;
    chk("serve_complete", 32'(k), 32'(ord.size()));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (n < 100 && (sb.size() != 0 || bus.res_valid)) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tagname);
    chk({tagname, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tagname, "_res_valid"}, 32'(bus.res_valid), 32'd0);
    chk({tagname, "_req_ready"}, 32'(bus.req_ready), 32'd0);
    chk({tagname, "_mul_start"}, 32'(bus.mul_start), 32'd0);
    chk({tagname, "_res_tag"}, 32'(bus.res_tag), 32'd0);
    chk({tagname, "_res_product"}, 32'(bus.res_product), 32'd0);
    chk({tagname, "_mcand"}, 32'(bus.mul_multiplicand), 32'd0);
    chk({tagname, "_mplier"}, 32'(bus.mul_multiplier), 32'd0);
  endtask

  initial begin : stim
    int acc;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.res_ready = 1'b1;
    rst_n         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // All four requesting from reset: grants 0,1,2,3,0.
    set_req(0, 8'h02, 8'h03); eprod[0] = 16'h0006;
    set_req(1, 8'hFF, 8'hFF); eprod[1] = 16'h0001;
    set_req(2, 8'h0A, 8'hF6); eprod[2] = 16'hFF9C;
    set_req(3, 8'hF9, 8'h09); eprod[3] = 16'hFFC1;
    pend_init[0] = 2; pend_init[1] = 1; pend_init[2] = 1; pend_init[3] = 1;
    ord.delete();
    ord.push_back(0); ord.push_back(1); ord.push_back(2); ord.push_back(3); ord.push_back(0);
    serve();
    drain();

    // Single requests; mul_start must be a one-cycle pulse.
    issue_one(0, 8'h05, 8'h03, 16'h000F, acc);
    chk("start_high", 32'(bus.mul_start), 32'd1);
    chk("busy_high", 32'(bus.busy), 32'd1);
    @(posedge clk); #1;
    chk("start_low", 32'(bus.mul_start), 32'd0);
    drain();
    issue_one(2, 8'hFC, 8'h07, 16'hFFE4, acc);
    drain();
    issue_one(1, 8'h80, 8'h80, 16'h4000, acc);
    drain();

    // Spurious done in the first WAIT cycle must be ignored.
    issue_one(3, 8'h7F, 8'h80, 16'hC080, acc);
    @(posedge clk); #1;
    inj_done = 1'b1;
    @(posedge clk); #1;
    inj_done = 1'b0;
    drain();

    // Response backpressure with req1 pending.
    bus.res_ready = 1'b0;
    issue_one(0, 8'h0C, 8'h0C, 16'h0090, acc);
    set_req(1, 8'hFD, 8'hFB);
    bus.req_valid[1] = 1'b1;
    for (int n = 0; n < 50 && !bus.res_valid; n++) begin
      @(posedge clk); #1;
    end
    chk("stall_valid_seen", 32'(bus.res_valid), 32'd1);
    for (int n = 0; n < 5; n++) begin
      @(posedge clk); #1;
      chk("stall_valid", 32'(bus.res_valid), 32'd1);
      chk("stall_tag", 32'(bus.res_tag), 32'd0);
      chk("stall_product", 32'(bus.res_product), 32'h0090);
      chk("stall_no_grant", 32'(bus.req_ready), 32'd0);
    end
    bus.res_ready = 1'b1;
    issue_one(1, 8'hFD, 8'hFB, 16'h000F, acc);
    chk("grant_after_rsp", 32'(acc - last_rsp_cyc), 32'd1);
    drain();

    // Reset during WAIT: asynchronous clear, no response, rr_ptr back to 0.
    issue_one(2, 8'h06, 8'h07, 16'h002A, acc);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("no_rsp_after_rst", 32'(bus.res_valid), 32'd0);
    set_req(0, 8'h01, 8'hFF); eprod[0] = 16'hFFFF;
    set_req(3, 8'h64, 8'h64); eprod[3] = 16'h2710;
    pend_init[0] = 1; pend_init[1] = 0; pend_init[2] = 0; pend_init[3] = 1;
    ord.delete();
    ord.push_back(0); ord.push_back(3);
    serve();
    drain();

    chk("rsp_count", 32'(n_rsp), 32'd13);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
